// File: rtl/im_pkg.sv
// -----------------------------------------------------------------------------
// im_pkg
// Shared definitions for the instruction-memory fetch responder:
//   im_state_e  - access FSM states (IDLE, ACCESS)
//   IM_BUBBLE   - instruction word returned when nothing valid is presented
//   MISS_CNT_W  - width of the saturating miss counter
// -----------------------------------------------------------------------------
package im_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } im_state_e;

    localparam logic [31:0] IM_BUBBLE  = 32'h0000_0000;
    localparam int unsigned MISS_CNT_W = 16;

endpackage

// File: rtl/im_fetch_buf.sv
// -----------------------------------------------------------------------------
// im_fetch_buf
// One-entry fetch buffer: valid/tag/data registers with fill and invalidate,
// plus a combinational hit compare against the requested word address.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   i_fill          - load i_fill_tag/i_fill_data and mark valid
//   i_fill_tag      - word address of the filled entry
//   i_fill_data     - instruction word to store
//   i_inval         - drop the entry; takes priority over a same-edge fill
//   i_lookup_tag    - word address to compare against the stored tag
//   o_hit           - entry valid and tag matches
//   o_data          - stored instruction word
// -----------------------------------------------------------------------------
module im_fetch_buf #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_fill_tag,
    input  logic [31:0]       i_fill_data,
    input  logic              i_inval,
    input  logic [ADDR_W-1:0] i_lookup_tag,
    output logic              o_hit,
    output logic [31:0]       o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [31:0]       r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            // Invalidate wins over a coincident fill: the word just read may
            // predate the memory rewrite that triggered the invalidate.
            if (i_inval)
                r_valid <= 1'b0;
            else if (i_fill)
                r_valid <= 1'b1;

            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_data <= i_fill_data;
            end
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule

// File: rtl/im_fetch_responder.sv
// -----------------------------------------------------------------------------
// im_fetch_responder
// Serves the fetch stage's PC request from a one-entry buffer (zero-cycle hit)
// and refills it from a synchronous-read SRAM on a miss, stalling the pipeline
// until the word is buffered.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   pc_in        - fetch address; only pc_in[ADDR_W+1:2] selects the word
//   fetch_req    - IF requests an instruction this cycle
//   inval        - single-cycle pulse dropping the buffered entry
//   instr_out    - instruction to IF (zero when not valid or on error)
//   instr_valid  - instr_out corresponds to pc_in this cycle
//   im_stall     - freeze PC and IF/ID
//   fetch_err    - misaligned pc_in with fetch_req
//   sram_cs      - SRAM chip select (read only)
//   sram_addr    - SRAM word address
//   sram_rdata   - SRAM read data
//   miss_cnt     - saturating count of misses since reset
// -----------------------------------------------------------------------------
module im_fetch_responder
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_in,
    input  logic                  fetch_req,
    input  logic                  inval,
    output logic [31:0]           instr_out,
    output logic                  instr_valid,
    output logic                  im_stall,
    output logic                  fetch_err,
    output logic                  sram_cs,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [31:0]           sram_rdata,
    output logic [MISS_CNT_W-1:0] miss_cnt
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    im_state_e             r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_W-1:0]     r_addr_q;
    logic [MISS_CNT_W-1:0] r_miss_cnt;

    logic [ADDR_W-1:0]     w_word_addr;
    logic                  w_misaligned;
    logic                  w_idle;
    logic                  w_hit;
    logic [31:0]           w_buf_data;
    logic                  w_miss;
    logic                  w_fill;
    logic                  w_unused_pc_hi;

    assign w_word_addr    = pc_in[ADDR_W+1:2];
    assign w_misaligned   = (pc_in[1:0] != 2'b00);
    assign w_unused_pc_hi = ^pc_in[31:ADDR_W+2];
    assign w_idle         = (r_state == IDLE);
    assign w_miss         = w_idle && fetch_req && !w_misaligned && !w_hit;
    assign w_fill         = (r_state == ACCESS) && (r_cnt == 4'd0);

    im_fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_fill       (w_fill),
        .i_fill_tag   (r_addr_q),
        .i_fill_data  (sram_rdata),
        .i_inval      (inval),
        .i_lookup_tag (w_word_addr),
        .o_hit        (w_hit),
        .o_data       (w_buf_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr_q   <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_addr_q <= w_word_addr;
                        r_cnt    <= CNT_INIT;
                        r_state  <= ACCESS;
                        if (r_miss_cnt != '1)
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    // The access runs to completion regardless of pc_in or
                    // fetch_req; IDLE re-evaluates the PC afterwards.
                    if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is held, since the IDLE decode alone
    // would otherwise raise im_stall/fetch_err from the live request inputs.
    always_comb begin
        instr_out   = IM_BUBBLE;
        instr_valid = 1'b0;
        im_stall    = 1'b0;
        fetch_err   = 1'b0;
        sram_cs     = 1'b0;
        sram_addr   = '0;
        if (!rst) begin
            if (r_state == ACCESS) begin
                sram_cs   = 1'b1;
                sram_addr = r_addr_q;
                im_stall  = 1'b1;
            end else if (fetch_req) begin
                if (w_misaligned) begin
                    fetch_err   = 1'b1;
                    instr_valid = 1'b1;
                end else if (w_hit) begin
                    instr_out   = w_buf_data;
                    instr_valid = 1'b1;
                end else begin
                    im_stall    = 1'b1;
                end
            end
        end
    end

    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_im_fetch_responder.sv
module tb_im_fetch_responder;
    import im_pkg::*;

    localparam int unsigned ADDR_W = 14;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           pc_in;
    logic                  fetch_req;
    logic                  inval;
    logic [31:0]           instr_out;
    logic                  instr_valid;
    logic                  im_stall;
    logic                  fetch_err;
    logic                  sram_cs;
    logic [ADDR_W-1:0]     sram_addr;
    logic [31:0]           sram_rdata = 32'h0;
    logic [MISS_CNT_W-1:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    im_fetch_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .fetch_req   (fetch_req),
        .inval       (inval),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .im_stall    (im_stall),
        .fetch_err   (fetch_err),
        .sram_cs     (sram_cs),
        .sram_addr   (sram_addr),
        .sram_rdata  (sram_rdata),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle synchronous read. Word 4 holds 0xDEADBEEF, every
    // other word holds 0xA5A5_0000 | word address.
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 14'd4) return 32'hDEAD_BEEF;
        return {16'hA5A5, 2'b00, a};
    endfunction

    always @(posedge clk) begin
        if (sram_cs) sram_rdata <= mem_word(sram_addr);
        else         sram_rdata <= 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Combined output check at the current sample point.
    task automatic chk_out(input string tag, input logic [31:0] ins, input logic v,
                           input logic st, input logic err, input logic cs,
                           input logic [31:0] addr, input logic [31:0] mc);
        chk({tag, ".instr_out"},   instr_out, ins);
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".im_stall"},    {31'd0, im_stall}, {31'd0, st});
        chk({tag, ".fetch_err"},   {31'd0, fetch_err}, {31'd0, err});
        chk({tag, ".sram_cs"},     {31'd0, sram_cs}, {31'd0, cs});
        chk({tag, ".sram_addr"},   {18'd0, sram_addr}, addr);
        chk({tag, ".miss_cnt"},    {16'd0, miss_cnt}, mc);
    endtask

    initial begin
        // Reset held with an active aligned request: everything must read 0.
        rst = 1'b1; fetch_req = 1'b1; pc_in = 32'h10; inval = 1'b0;
        #1;
        chk_out("reset", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick(); tick();
        chk_out("reset_hold", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Cold miss to 0x10 (word 4): 3 stall cycles, then hit.
        rst = 1'b0; #1;
        chk_out("miss0_c1", 32'h0, 0, 1, 0, 0, 32'h0, 32'h0);
        tick();
        chk_out("miss0_c2", 32'h0, 0, 1, 0, 1, 32'h4, 32'h1);
        tick();
        chk_out("miss0_c3", 32'h0, 0, 1, 0, 1, 32'h4, 32'h1);
        tick();
        chk_out("hit0_c4", 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h0, 32'h1);
        tick();
        chk_out("hit0_c5", 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h0, 32'h1);
        tick();
        chk_out("hit0_c6", 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h0, 32'h1);

        // Next sequential PC misses.
        pc_in = 32'h14; #1;
        chk_out("miss1_c1", 32'h0, 0, 1, 0, 0, 32'h0, 32'h1);
        tick();
        chk_out("miss1_c2", 32'h0, 0, 1, 0, 1, 32'h5, 32'h2);
        tick();
        chk_out("miss1_c3", 32'h0, 0, 1, 0, 1, 32'h5, 32'h2);
        tick();
        chk_out("hit1", 32'hA5A5_0005, 1, 0, 0, 0, 32'h0, 32'h2);

        // Misaligned PC: bubble with error, no stall, no access, no count.
        pc_in = 32'h12; #1;
        chk_out("misalign", 32'h0, 1, 0, 1, 0, 32'h0, 32'h2);
        tick();
        chk_out("misalign_hold", 32'h0, 1, 0, 1, 0, 32'h0, 32'h2);

        // No request: quiet outputs.
        fetch_req = 1'b0; pc_in = 32'h20; #1;
        chk_out("noreq", 32'h0, 0, 0, 0, 0, 32'h0, 32'h2);

        // Upper PC bits alias: 0x0001_0014 is word 5, already buffered.
        fetch_req = 1'b1; pc_in = 32'h0001_0014; #1;
        chk_out("alias_hit", 32'hA5A5_0005, 1, 0, 0, 0, 32'h0, 32'h2);

        // Miss to 0x20 with inval on the fill edge: buffer ends invalid.
        pc_in = 32'h20; #1;
        chk_out("inv_c1", 32'h0, 0, 1, 0, 0, 32'h0, 32'h2);
        tick();
        chk_out("inv_c2", 32'h0, 0, 1, 0, 1, 32'h8, 32'h3);
        tick();
        inval = 1'b1; #1;
        chk_out("inv_c3", 32'h0, 0, 1, 0, 1, 32'h8, 32'h3);
        tick();
        inval = 1'b0; #1;
        chk_out("inv_remiss", 32'h0, 0, 1, 0, 0, 32'h0, 32'h3);
        tick();
        chk_out("inv_r_c2", 32'h0, 0, 1, 0, 1, 32'h8, 32'h4);
        tick();
        tick();
        chk_out("inv_hit", 32'hA5A5_0008, 1, 0, 0, 0, 32'h0, 32'h4);

        // Reset during the second ACCESS cycle of a miss to 0x30 (word 12).
        pc_in = 32'h30; #1;
        chk_out("rst_c1", 32'h0, 0, 1, 0, 0, 32'h0, 32'h4);
        tick();
        chk_out("rst_c2", 32'h0, 0, 1, 0, 1, 32'hC, 32'h5);
        tick();
        rst = 1'b1; #1;
        chk_out("rst_mid", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        rst = 1'b0; #1;
        chk_out("rst_remiss", 32'h0, 0, 1, 0, 0, 32'h0, 32'h0);
        tick();
        chk_out("rst_r_c2", 32'h0, 0, 1, 0, 1, 32'hC, 32'h1);
        tick();
        tick();
        chk_out("rst_hit", 32'hA5A5_000C, 1, 0, 0, 0, 32'h0, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im_fetch_responder.md
# im_fetch_responder

Instruction-memory responder serving the fetch stage's PC request: takes the PC driven by IF, returns the 32-bit instruction and an `im_stall` to the hazard controller. Sits between IF and a synchronous-read instruction SRAM. Holds a one-entry fetch buffer so a repeated PC is answered in zero cycles. A miss runs a counted SRAM access FSM and stalls the pipeline until the word is buffered.

## Interface
Parameters:
- `ADDR_W`, 14: word-address width into SRAM; `pc_in[ADDR_W+1:2]` used, upper PC bits ignored (alias).
- `WAIT_CYCLES`, 1: SRAM read latency in cycles after address; legal range 1–15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_in`  in  32  fetch address from IF PC output.
- `fetch_req`  in  1  IF requests an instruction this cycle.
- `inval`  in  1  single-cycle pulse; drops buffered entry (IM rewritten).
- `instr_out`  out  32  instruction to IF; 32'h0 when `instr_valid`=0 or on error.
- `instr_valid`  out  1  `instr_out` corresponds to `pc_in` this cycle.
- `im_stall`  out  1  to hazard controller; freeze PC and IF/ID.
- `fetch_err`  out  1  misaligned `pc_in` with `fetch_req`.
- `sram_cs`  out  1  SRAM chip select, read only.
- `sram_addr`  out  ADDR_W  SRAM word address.
- `sram_rdata`  in  32  SRAM read data.
- `miss_cnt`  out  16  saturating count of misses since reset.

## Operation
- States: IDLE, ACCESS.
- Buffer: `buf_valid`, `buf_tag[ADDR_W-1:0]`, `buf_data[31:0]`.
- IDLE, `fetch_req`=0: `instr_valid`=0, `im_stall`=0, `instr_out`=0, no access.
- IDLE, `fetch_req`=1, `pc_in[1:0]`≠0: `fetch_err`=1, `instr_valid`=1, `instr_out`=0 (bubble). No stall, no access, no miss count.
- IDLE, hit (`buf_valid` and `buf_tag`==`pc_in[ADDR_W+1:2]`): combinational `instr_out`=`buf_data`, `instr_valid`=1, `im_stall`=0.
- IDLE, miss: `im_stall`=1, `instr_valid`=0. On the edge: `addr_q`←word address, `cnt`←`WAIT_CYCLES`, state←ACCESS, `miss_cnt`+1 (saturates at 16'hFFFF).
- ACCESS: `sram_cs`=1, `sram_addr`=`addr_q`, `im_stall`=1, `instr_valid`=0, `fetch_err`=0. Each edge with `cnt`≠0: `cnt`−1. Edge with `cnt`==0: `buf_data`←`sram_rdata`, `buf_tag`←`addr_q`, `buf_valid`←1, state←IDLE.
- Outside ACCESS: `sram_cs`=0, `sram_addr`=0.
- An in-flight access always completes, even if `pc_in` or `fetch_req` changes. IDLE then re-evaluates the current `pc_in`; a different PC causes a new miss.
- `inval`: clears `buf_valid` on the edge. If it coincides with the fill edge, `inval` wins and the buffer ends invalid.

## Timing
- Hit latency 0 cycles.
- Miss: `im_stall` high for `WAIT_CYCLES`+2 cycles (IDLE miss cycle plus `WAIT_CYCLES`+1 ACCESS cycles). The next cycle hits with `instr_valid`=1.
- SRAM contract: data for the address presented in the first ACCESS cycle is valid `WAIT_CYCLES` cycles later and held while `sram_addr` is stable.
- Reset (async, any state including mid-ACCESS): state IDLE; `buf_valid`=0, `buf_tag`=0, `buf_data`=0, `cnt`=0, `addr_q`=0, `miss_cnt`=0.
- While in reset, all outputs are 0: `sram_cs`, `im_stall`, `instr_valid`, `fetch_err`, `instr_out`.

## Structure
- Shared package `im_pkg`:
  - state enum `im_state_e` {IDLE, ACCESS};
  - `IM_BUBBLE` = 32'h0000_0000;
  - `MISS_CNT_W` = 16.
- One natural sub-module, `im_fetch_buf`: valid/tag/data registers with fill, invalidate and a combinational hit compare.
- FSM, counter and `miss_cnt` live in the top.

## Test plan
- Reset with `fetch_req`=1, `pc_in`=0x10 → all outputs 0, `miss_cnt`=0. After release, a miss begins on the first cycle.
- Cold miss, `WAIT_CYCLES`=1, `pc_in`=0x0000_0010, SRAM word 4 = 0xDEADBEEF:
  - `im_stall`=1 for 3 cycles;
  - `sram_cs`=1 with `sram_addr`=0x004 for cycles 2–3;
  - cycle 4: `instr_valid`=1, `instr_out`=0xDEADBEEF, `miss_cnt`=1.
- Hold `pc_in`=0x10 further cycles → hit each cycle, `sram_cs`=0, `miss_cnt` stays 1. Then `pc_in`=0x14 → new 3-cycle stall, `sram_addr`=0x005.
- `pc_in`=0x0000_0012, `fetch_req`=1 → same cycle: `fetch_err`=1, `instr_valid`=1, `instr_out`=0, `im_stall`=0, `sram_cs`=0.
- `inval` pulsed on the fill edge of a miss to 0x20 → buffer invalid. The next cycle misses again, `miss_cnt` increments by 2 total.
- `rst` asserted during the second ACCESS cycle → `sram_cs` and `im_stall` drop immediately. After release, the same PC misses again, `miss_cnt` restarts at 1.
